// File: rtl/rv_fp_class_decode_pkg.sv
// Shared FPU class definitions: class bit positions, legal one-hot class patterns, decoder FSM states.
// Pure declarations; no logic, no latency, no flow control.
package rv_fp_class_decode_pkg;

    localparam int CLS_BITS      = 7;
    localparam int CLS_NORMAL    = 6;
    localparam int CLS_ZERO      = 5;
    localparam int CLS_SUBNORMAL = 4;
    localparam int CLS_INF       = 3;
    localparam int CLS_NAN       = 2;
    localparam int CLS_QUIET     = 1;
    localparam int CLS_SIGNALING = 0;

    localparam logic [CLS_BITS-1:0] CLS_PAT_NORMAL    = 7'b1000000;
    localparam logic [CLS_BITS-1:0] CLS_PAT_ZERO      = 7'b0100000;
    localparam logic [CLS_BITS-1:0] CLS_PAT_SUBNORMAL = 7'b0010000;
    localparam logic [CLS_BITS-1:0] CLS_PAT_INF       = 7'b0001000;
    localparam logic [CLS_BITS-1:0] CLS_PAT_QNAN      = 7'b0000110;
    localparam logic [CLS_BITS-1:0] CLS_PAT_SNAN      = 7'b0000101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rv_fp_class_decode_lane.sv
// Single-lane class vector -> canonical IEEE-754 pattern decoder.
// Combinational, zero latency; no flow control.
module rv_fp_class_decode_lane
    import rv_fp_class_decode_pkg::*;
#(
    parameter int EXP_BITS = 8,
    parameter int MAN_BITS = 23
) (
    input  logic [CLS_BITS-1:0]          clss,
    input  logic                         sign,
    output logic [EXP_BITS+MAN_BITS:0]   data,
    output logic                         err
);

    localparam logic [EXP_BITS-1:0] EXP_ONES = {EXP_BITS{1'b1}};
    localparam logic [EXP_BITS-1:0] EXP_BIAS = {1'b0, {(EXP_BITS-1){1'b1}}};
    localparam logic [MAN_BITS-1:0] MAN_ZERO = '0;
    localparam logic [MAN_BITS-1:0] MAN_ONE  = {{(MAN_BITS-1){1'b0}}, 1'b1};
    localparam logic [MAN_BITS-1:0] MAN_QNAN = {1'b1, {(MAN_BITS-1){1'b0}}};

    always_comb begin
        data = {1'b0, EXP_ONES, MAN_QNAN};
        err  = 1'b0;
        case (clss)
            CLS_PAT_NORMAL:    data = {sign, EXP_BIAS, MAN_ZERO};
            CLS_PAT_ZERO:      data = {sign, {EXP_BITS{1'b0}}, MAN_ZERO};
            CLS_PAT_SUBNORMAL: data = {sign, {EXP_BITS{1'b0}}, MAN_ONE};
            CLS_PAT_INF:       data = {sign, EXP_ONES, MAN_ZERO};
            CLS_PAT_QNAN:      data = {1'b0, EXP_ONES, MAN_QNAN};
            CLS_PAT_SNAN:      data = {sign, EXP_ONES, MAN_ONE};
            // Anything not exactly one-hot-legal becomes canonical qNaN and is flagged
            default:           err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_fp_class_decode.sv
// Multi-lane class decoder: serially materialises one active lane per cycle under a small FSM.
// Latency 1 + popcount(mask) cycles from accept to out_valid; holds result in DONE until out_ready.
module rv_fp_class_decode
    import rv_fp_class_decode_pkg::*;
#(
    parameter int EXP_BITS  = 8,
    parameter int MAN_BITS  = 23,
    parameter int NUM_LANES = 4,
    parameter int TAG_BITS  = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [TAG_BITS-1:0]                      in_tag,
    input  logic [NUM_LANES-1:0]                     in_mask,
    input  logic [NUM_LANES*CLS_BITS-1:0]            in_clss,
    input  logic [NUM_LANES-1:0]                     in_sign,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [TAG_BITS-1:0]                      out_tag,
    output logic [NUM_LANES-1:0]                     out_mask,
    output logic [NUM_LANES*(1+EXP_BITS+MAN_BITS)-1:0] out_data,
    output logic [NUM_LANES-1:0]                     out_err,
    output logic                                     busy
);

    localparam int W     = 1 + EXP_BITS + MAN_BITS;
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    state_e                          state;
    logic [PTR_W-1:0]                ptr;
    logic [NUM_LANES-1:0]            mask_q;
    logic [NUM_LANES*CLS_BITS-1:0]   clss_q;
    logic [NUM_LANES-1:0]            sign_q;

    logic [PTR_W-1:0]                first_idx;
    logic [PTR_W-1:0]                nxt_idx;
    logic                            nxt_found;
    logic [CLS_BITS-1:0]             lane_clss;
    logic [W-1:0]                    lane_data;
    logic                            lane_err;

    // Descending scan so the last hit wins: lowest set bit overall / lowest set bit above ptr
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (in_mask[i]) first_idx = PTR_W'(i);
            if (mask_q[i] && (PTR_W'(i) > ptr)) begin
                nxt_idx   = PTR_W'(i);
                nxt_found = 1'b1;
            end
        end
    end

    assign lane_clss = clss_q[CLS_BITS*ptr +: CLS_BITS];

    rv_fp_class_decode_lane #(
        .EXP_BITS (EXP_BITS),
        .MAN_BITS (MAN_BITS)
    ) u_lane (
        .clss (lane_clss),
        .sign (sign_q[ptr]),
        .data (lane_data),
        .err  (lane_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            mask_q   <= '0;
            clss_q   <= '0;
            sign_q   <= '0;
            out_tag  <= '0;
            out_mask <= '0;
            out_data <= '0;
            out_err  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_tag  <= in_tag;
                        out_mask <= in_mask;
                        mask_q   <= in_mask;
                        clss_q   <= in_clss;
                        sign_q   <= in_sign;
                        out_data <= '0;
                        out_err  <= '0;
                        ptr      <= first_idx;
                        state    <= (in_mask != '0) ? ST_BUSY : ST_DONE;
                    end
                end
                ST_BUSY: begin
                    out_data[W*ptr +: W] <= lane_data;
                    out_err[ptr]         <= lane_err;
                    if (nxt_found) ptr   <= nxt_idx;
                    else           state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rv_fp_class_decode.sv
// Randomized and directed bench for rv_fp_class_decode against a lane-level IEEE-754 reference model.
module tb_rv_fp_class_decode;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_tag;
    logic [3:0]   in_mask;
    logic [27:0]  in_clss;
    logic [3:0]   in_sign;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_tag;
    logic [3:0]   out_mask;
    logic [127:0] out_data;
    logic [3:0]   out_err;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv_fp_class_decode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tag    (in_tag),
        .in_mask   (in_mask),
        .in_clss   (in_clss),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_mask  (out_mask),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: float32 meaning of each class; bit 32 is the illegal-pattern flag
    function automatic logic [32:0] ref_lane(input logic [6:0] c, input logic s);
        logic [31:0] sb;
        sb = s ? 32'h8000_0000 : 32'h0;
        case (c)
            7'b1000000: return {1'b0, sb | 32'h3F80_0000};
            7'b0100000: return {1'b0, sb};
            7'b0010000: return {1'b0, sb | 32'h0000_0001};
            7'b0001000: return {1'b0, sb | 32'h7F80_0000};
            7'b0000110: return {1'b0, 32'h7FC0_0000};
            7'b0000101: return {1'b0, sb | 32'h7F80_0001};
            default:    return {1'b1, 32'h7FC0_0000};
        endcase
    endfunction

    task automatic txn(input logic [3:0] tag, input logic [3:0] mask, input logic [27:0] clss,
                       input logic [3:0] sign, input int hold);
        logic [127:0] exp_data;
        logic [3:0]   exp_err;
        logic [32:0]  r;
        int           p;
        int           k;
        int           w;
        exp_data = '0;
        exp_err  = '0;
        p        = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                r = ref_lane(clss[7*i +: 7], sign[i]);
                exp_data[32*i +: 32] = r[31:0];
                exp_err[i] = r[32];
                p++;
            end
        end
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) check("in_ready_timeout", 1'b0, 1'b1);
        in_valid = 1'b1; in_tag = tag; in_mask = mask; in_clss = clss; in_sign = sign;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_clss  = $urandom;
        in_sign  = 4'($urandom);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("latency", 128'(k), 128'(p));
        check("data", out_data, exp_data);
        check("err", 128'(out_err), 128'(exp_err));
        check("tag", 128'(out_tag), 128'(tag));
        check("mask", 128'(out_mask), 128'(mask));
        check("done_flags", 128'({in_ready, busy}), 128'(2'b01));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_stable", {out_valid, in_ready, out_err, out_data[121:0]},
                  {1'b1, 1'b0, exp_err, exp_data[121:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    endtask

    logic [6:0] legal [6] = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0000110, 7'b0000101};

    initial begin
        logic [27:0] c;
        reset = 1'b1; in_valid = 1'b0; in_tag = '0; in_mask = '0; in_clss = '0; in_sign = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, busy, out_tag, out_mask, out_err, out_data[116:0]},
              {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 117'h0});
        check("reset_data_hi", 128'(out_data[127:117]), 128'h0);
        reset = 1'b0;

        // Directed cases: single zero, all-lane mix, subnormal, illegal pattern, empty mask, long hold
        txn(4'h3, 4'b0001, {21'h0, 7'b0100000}, 4'b0001, 0);
        txn(4'h5, 4'b1111, {7'b0000101, 7'b0000110, 7'b0001000, 7'b1000000}, 4'b0110, 0);
        txn(4'h6, 4'b1111, {7'b0000101, 7'b0000110, 7'b0001000, 7'b0010000}, 4'b0110, 0);
        txn(4'h7, 4'b0100, {7'h0, 7'b1100000, 14'h0}, 4'b0000, 0);
        txn(4'hA, 4'b0000, 28'h0, 4'h0, 0);
        txn(4'h9, 4'b1010, {7'b0001000, 7'b0000000, 7'b1000000, 7'b1111111}, 4'b1111, 10);

        // Reset after the first of three active lanes has been decoded
        in_valid = 1'b1; in_tag = 4'hC; in_mask = 4'b0111; in_sign = 4'b0111;
        in_clss = {7'h0, 7'b0001000, 7'b0001000, 7'b1000000};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", {in_ready, out_valid, busy, out_tag, out_mask, out_err, out_data[116:0]},
              {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 117'h0});
        reset = 1'b0;
        txn(4'hD, 4'b0111, {7'h0, 7'b0001000, 7'b0001000, 7'b1000000}, 4'b0111, 1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++)
                c[7*i +: 7] = ($urandom_range(4) == 0) ? 7'($urandom) : legal[$urandom_range(5)];
            txn(4'($urandom), 4'($urandom), c, 4'($urandom), $urandom_range(3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
